// File: rtl/seg_scan_decoder.sv
// Sampling decoder for a time-multiplexed active-low 7-segment bus; assembles one value per digit into a frame.
// Optional macro SEG_HEX_EN: also decode A,b,C,d,E,F patterns as valid values.
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel_n,
    input  logic                    clear,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [4*NUM_DIGITS-1:0] frame_data,
    output logic [NUM_DIGITS-1:0]   frame_blank,
    output logic                    frame_err
);

    // state   | meaning
    // COLLECT | gathering one capture per digit into the slots
    // HOLD    | frame presented, waiting for frame_ready; captures ignored
    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    localparam int SW = 7 + NUM_DIGITS;
    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    state_t state, state_nxt;

    logic [SW-1:0]           sync1, sync2, s_prev;
    logic [7:0]              cnt, cnt_nxt;
    logic [NUM_DIGITS-1:0]   sel_oh;
    logic                    sel_ok;
    logic                    cap_fire;
    logic [5:0]              dec;

    logic                    cap_q;
    logic [NUM_DIGITS-1:0]   cap_oh_q;
    logic [3:0]              cap_val_q;
    logic                    cap_blank_q;
    logic                    cap_err_q;

    logic [4*NUM_DIGITS-1:0] slot_data, data_nxt;
    logic [NUM_DIGITS-1:0]   slot_blank, blank_nxt;
    logic [NUM_DIGITS-1:0]   seen, seen_nxt;
    logic                    err_sticky, err_nxt;
    logic                    load_frame, valid_nxt;

    // returns {err, blank, value}
    function automatic logic [5:0] decode(input logic [6:0] p);
        logic [5:0] r;
        r = {2'b10, 4'hF};
        case (p)
            7'b0000001: r = {2'b00, 4'h0};
            7'b1001111: r = {2'b00, 4'h1};
            7'b0010010: r = {2'b00, 4'h2};
            7'b0000110: r = {2'b00, 4'h3};
            7'b1001100: r = {2'b00, 4'h4};
            7'b0100100: r = {2'b00, 4'h5};
            7'b0100000: r = {2'b00, 4'h6};
            7'b0001111: r = {2'b00, 4'h7};
            7'b0000000: r = {2'b00, 4'h8};
            7'b0000100: r = {2'b00, 4'h9};
            7'b1111111: r = {2'b01, 4'h0};
`ifdef SEG_HEX_EN
            7'b0001000: r = {2'b00, 4'hA};
            7'b1100000: r = {2'b00, 4'hB};
            7'b0110001: r = {2'b00, 4'hC};
            7'b1000010: r = {2'b00, 4'hD};
            7'b0110000: r = {2'b00, 4'hE};
            7'b0111000: r = {2'b00, 4'hF};
`endif
            default:    r = {2'b10, 4'hF};
        endcase
        return r;
    endfunction

    assign sel_oh = ~sync2[NUM_DIGITS-1:0];
    assign sel_ok = (sel_oh != '0) && ((sel_oh & (sel_oh - NUM_DIGITS'(1))) == '0);
    assign dec    = decode(sync2[SW-1:NUM_DIGITS]);

    always_comb begin
        cnt_nxt = cnt;
        if (sync2 != s_prev) begin
            cnt_nxt = 8'd1;
        end else if (cnt != STABLE_C) begin
            cnt_nxt = cnt + 8'd1;
        end
    end

    // exactly one capture per stable period: only on the transition into saturation
    assign cap_fire = (cnt_nxt == STABLE_C) && (cnt != STABLE_C) && sel_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            s_prev      <= '0;
            cnt         <= '0;
            cap_q       <= 1'b0;
            cap_oh_q    <= '0;
            cap_val_q   <= '0;
            cap_blank_q <= 1'b0;
            cap_err_q   <= 1'b0;
        end else begin
            sync1       <= {seg_in, dig_sel_n};
            sync2       <= sync1;
            s_prev      <= sync2;
            cnt         <= clear ? 8'd0 : cnt_nxt;
            cap_q       <= cap_fire && !clear;
            cap_oh_q    <= sel_oh;
            cap_val_q   <= dec[3:0];
            cap_blank_q <= dec[4];
            cap_err_q   <= dec[5];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        data_nxt   = slot_data;
        blank_nxt  = slot_blank;
        seen_nxt   = seen;
        err_nxt    = err_sticky;
        load_frame = 1'b0;
        valid_nxt  = frame_valid;

        if (cap_q && (state == COLLECT)) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_oh_q[i]) begin
                    data_nxt[4*i +: 4] = cap_val_q;
                    blank_nxt[i]       = cap_blank_q;
                end
            end
            seen_nxt = seen | cap_oh_q;
            err_nxt  = err_sticky | cap_err_q;
        end

        case (state)
            COLLECT: begin
                if (&seen_nxt) begin
                    load_frame = 1'b1;
                    valid_nxt  = 1'b1;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                if (frame_valid && frame_ready) begin
                    valid_nxt = 1'b0;
                    seen_nxt  = '0;
                    err_nxt   = 1'b0;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase

        // clear wins over the handshake and discards a coincident capture
        if (clear) begin
            state_nxt  = COLLECT;
            data_nxt   = slot_data;
            blank_nxt  = slot_blank;
            seen_nxt   = '0;
            err_nxt    = 1'b0;
            load_frame = 1'b0;
            valid_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_data   <= '0;
            slot_blank  <= '0;
            seen        <= '0;
            err_sticky  <= 1'b0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_blank <= '0;
            frame_err   <= 1'b0;
        end else begin
            slot_data   <= data_nxt;
            slot_blank  <= blank_nxt;
            seen        <= seen_nxt;
            err_sticky  <= err_nxt;
            frame_valid <= valid_nxt;
            if (load_frame) begin
                frame_data  <= data_nxt;
                frame_blank <= blank_nxt;
                frame_err   <= err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: vector table, hand-written corner sequences and a randomized scan against a frame-level model.
module tb_seg_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    seg_in;
    logic [ND-1:0] dig_sel_n;
    logic          clear;
    logic          frame_valid;
    logic          frame_ready;
    logic [4*ND-1:0] frame_data;
    logic [ND-1:0] frame_blank;
    logic          frame_err;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .dig_sel_n  (dig_sel_n),
        .clear      (clear),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_data (frame_data),
        .frame_blank(frame_blank),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // digit-value -> active-low pattern (abc_defg), 10..15 are the hex letters
    logic [6:0] code [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // frame-level reference model
    logic        m_valid;
    logic [3:0]  m_seen;
    logic [3:0]  m_val [4];
    logic [3:0]  m_blank;
    logic        m_err;
    logic [15:0] m_fdata;
    logic [3:0]  m_fblank;
    logic        m_ferr;
    logic [10:0] m_prev;
    logic        m_prev_ok;

    typedef struct packed {
        logic [27:0] pats;   // {d3, d2, d1, d0}
        logic [15:0] d;
        logic [3:0]  b;
        logic        e;
    } vec_t;
    vec_t vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_dec(input logic [6:0] p, output logic [3:0] v, output logic b, output logic e);
        int top;
        logic found;
        v = 4'hF; b = 1'b0; e = 1'b0; found = 1'b0;
`ifdef SEG_HEX_EN
        top = 16;
`else
        top = 10;
`endif
        if (p == 7'h7F) begin
            v = 4'h0; b = 1'b1; found = 1'b1;
        end else begin
            for (int i = 0; i < top; i++) begin
                if (code[i] == p) begin
                    v = 4'(i); found = 1'b1;
                end
            end
        end
        if (!found) e = 1'b1;
    endtask

    task automatic model_reset();
        m_valid = 0; m_seen = 0; m_blank = 0; m_err = 0;
        m_fdata = 0; m_fblank = 0; m_ferr = 0; m_prev = 0; m_prev_ok = 0;
        for (int i = 0; i < 4; i++) m_val[i] = 0;
    endtask

    // a held (strobe, pattern) pair is captured once if long enough, one-low and new
    task automatic model_step(input logic [3:0] ds, input logic [6:0] p, input int n);
        logic [10:0] cur;
        logic [3:0] v;
        logic b, e;
        cur = {ds, p};
        if (n >= SC && $countones(~ds) == 1 && !(m_prev_ok && cur == m_prev) && !m_valid) begin
            model_dec(p, v, b, e);
            for (int i = 0; i < 4; i++) begin
                if (!ds[i]) begin
                    m_val[i] = v; m_blank[i] = b; m_seen[i] = 1'b1;
                end
            end
            m_err = m_err | e;
            if (m_seen == 4'hF) begin
                m_valid  = 1'b1;
                m_fdata  = {m_val[3], m_val[2], m_val[1], m_val[0]};
                m_fblank = m_blank;
                m_ferr   = m_err;
            end
        end
        m_prev = cur; m_prev_ok = 1'b1;
    endtask

    task automatic drive(input logic [3:0] ds, input logic [6:0] p, input int n);
        seg_in = p; dig_sel_n = ds;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan_digit(input logic [3:0] ds, input logic [6:0] p, input int n);
        drive(ds, p, n);
        model_step(ds, p, n);
    endtask

    function automatic logic [3:0] dsel(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic pulse_ready();
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
        if (m_valid) begin
            m_valid = 0; m_seen = 0; m_err = 0;
        end
    endtask

    task automatic check_frame(input string tag);
        check({tag, ".valid"}, frame_valid, m_valid);
        check({tag, ".data"},  frame_data,  m_fdata);
        check({tag, ".blank"}, frame_blank, m_fblank);
        check({tag, ".err"},   frame_err,   m_ferr);
    endtask

    task automatic scan4(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] p3);
        scan_digit(dsel(0), p0, 8);
        scan_digit(dsel(1), p1, 8);
        scan_digit(dsel(2), p2, 8);
        scan_digit(dsel(3), p3, 8);
    endtask

    initial begin
        int sel, r, n;
        logic [3:0] ds;
        logic [6:0] p;

        vt[0] = '{{7'h4C, 7'h12, 7'h01, 7'h12}, 16'h4202, 4'h0, 1'b0};
        vt[1] = '{{7'h4F, 7'h4F, 7'h4F, 7'h4F}, 16'h1111, 4'h0, 1'b0};
        vt[2] = '{{7'h00, 7'h0F, 7'h20, 7'h24}, 16'h8765, 4'h0, 1'b0};
`ifdef SEG_HEX_EN
        vt[3] = '{{7'h08, 7'h7F, 7'h06, 7'h04}, 16'hA039, 4'h4, 1'b0};
        vt[5] = '{{7'h01, 7'h01, 7'h30, 7'h55}, 16'h00EF, 4'h0, 1'b1};
`else
        vt[3] = '{{7'h08, 7'h7F, 7'h06, 7'h04}, 16'hF039, 4'h4, 1'b1};
        vt[5] = '{{7'h01, 7'h01, 7'h30, 7'h55}, 16'h00FF, 4'h0, 1'b1};
`endif
        vt[4] = '{{7'h7F, 7'h7F, 7'h7F, 7'h7F}, 16'h0000, 4'hF, 1'b0};

        seg_in = 7'h7F; dig_sel_n = 4'hF; clear = 0; frame_ready = 0; rst_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset.valid", frame_valid, 0);
        check("reset.data",  frame_data,  0);
        check("reset.blank", frame_blank, 0);
        check("reset.err",   frame_err,   0);
        rst_n = 1;
        drive(4'hF, 7'h7F, 4);

        // table vectors, including valid-rise latency after the last capture
        for (int v = 0; v < 6; v++) begin
            for (int d = 0; d < 3; d++) scan_digit(dsel(d), vt[v].pats[7*d +: 7], 8);
            check($sformatf("vec%0d.early", v), frame_valid, 0);
            drive(dsel(3), vt[v].pats[21 +: 7], 6);
            check($sformatf("vec%0d.lat_pre", v), frame_valid, 0);
            drive(dsel(3), vt[v].pats[21 +: 7], 1);
            check($sformatf("vec%0d.lat_rise", v), frame_valid, 1);
            drive(dsel(3), vt[v].pats[21 +: 7], 1);
            model_step(dsel(3), vt[v].pats[21 +: 7], 8);
            check($sformatf("vec%0d.data", v),  frame_data,  vt[v].d);
            check($sformatf("vec%0d.blank", v), frame_blank, vt[v].b);
            check($sformatf("vec%0d.err", v),   frame_err,   vt[v].e);
            pulse_ready();
            check($sformatf("vec%0d.ack", v), frame_valid, 0);
        end

        // backpressure
        scan4(code[2], code[0], code[2], code[4]);
        check("bp.first", frame_data, 16'h4202);
        scan4(code[1], code[1], code[1], code[1]);
        check("bp.hold_valid", frame_valid, 1);
        check("bp.hold_data",  frame_data,  16'h4202);
        pulse_ready();
        check("bp.ack", frame_valid, 0);
        scan4(code[1], code[1], code[1], code[1]);
        check("bp.second_valid", frame_valid, 1);
        check("bp.second_data",  frame_data,  16'h1111);
        pulse_ready();

        // glitch on digit1 and a two-low strobe
        scan_digit(dsel(0), code[5], 8);
        scan_digit(dsel(1), code[7], 3);
        scan_digit(dsel(1), code[9], 8);
        scan_digit(dsel(2), code[3], 8);
        scan_digit(4'b1100, code[8], 8);
        check("glitch.no_early", frame_valid, 0);
        scan_digit(dsel(3), code[6], 8);
        check("glitch.valid", frame_valid, 1);
        check("glitch.data",  frame_data,  16'h6395);
        pulse_ready();

        // randomized scan against the model
        for (int k = 0; k < 80; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7) ds = dsel($urandom_range(0, 3));
            else         ds = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 17);
            if (r < 16)       p = code[r];
            else if (r == 16) p = 7'h7F;
            else              p = 7'($urandom);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(8, 11);
            scan_digit(ds, p, n);
            check_frame($sformatf("rnd%0d", k));
            if (m_valid && $urandom_range(0, 1) == 1) begin
                pulse_ready();
                check($sformatf("rnd%0d.ack", k), frame_valid, 0);
            end
        end
        if (m_valid) pulse_ready();

        // clear in HOLD together with frame_ready
        scan4(code[3], code[4], code[5], code[6]);
        check("clr.valid_before", frame_valid, 1);
        scan_digit(4'hF, 7'h7F, 8);
        clear = 1; frame_ready = 1;
        @(posedge clk); #1;
        clear = 0; frame_ready = 0;
        m_valid = 0; m_seen = 0; m_err = 0; m_prev_ok = 0;
        check("clr.valid", frame_valid, 0);
        drive(4'hF, 7'h7F, 3);
        check("clr.stays_low", frame_valid, 0);
        scan_digit(dsel(0), code[7], 8);
        scan_digit(dsel(1), code[8], 8);
        scan_digit(dsel(2), code[9], 8);
        check("clr.seen_empty", frame_valid, 0);
        check("clr.data_kept", frame_data, 16'h6543);
        scan_digit(dsel(3), code[1], 8);
        check("clr.new_valid", frame_valid, 1);
        check("clr.new_data", frame_data, 16'h1987);
        pulse_ready();

        // reset mid-frame after two captures
        scan_digit(dsel(0), code[2], 8);
        scan_digit(dsel(1), code[3], 8);
        scan_digit(4'hF, 7'h7F, 2);
        rst_n = 0;
        #1;
        model_reset();
        check_frame("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        scan_digit(dsel(2), code[4], 8);
        scan_digit(dsel(3), code[5], 8);
        check("rst.partial", frame_valid, 0);
        scan_digit(dsel(0), code[6], 8);
        scan_digit(dsel(1), code[7], 8);
        check_frame("rst.full");
        check("rst.data_const", frame_data, 16'h5476);
        pulse_ready();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
